// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
//   Carries the pipeline hazard, exception and divider signals exchanged
//   between the pipeline datapath and the stall/flush sequencer.
//
//   Pipeline -> controller:
//     inst_busy      IF fetch outstanding on the instruction bus
//     data_busy      MEM access outstanding on the data bus
//     id_load_use    ID instruction depends on a load currently in EX
//     ex_is_div      DIV/DIVU instruction valid in EX
//     exc_in         exception committed in MEM this cycle
//     exc_handler_pc redirect target for exc_in
//   Controller -> pipeline:
//     stall[3:0]     {data, exe, id, inst}
//     flush          clear all pipeline registers at this edge
//     pc_redirect    IF loads redirect_pc this cycle
//     redirect_pc    new fetch address
//     inst_discard   drop the instruction returned by the outstanding fetch
//     div_start      one-cycle start pulse to the divider
//     div_done       divider result valid in EX
//
//   Modports: master = pipeline side, slave = controller side.
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if;
  logic        inst_busy;
  logic        data_busy;
  logic        id_load_use;
  logic        ex_is_div;
  logic        exc_in;
  logic [31:0] exc_handler_pc;

  logic [3:0]  stall;
  logic        flush;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        inst_discard;
  logic        div_start;
  logic        div_done;

  modport master (
    output inst_busy, data_busy, id_load_use, ex_is_div, exc_in, exc_handler_pc,
    input  stall, flush, pc_redirect, redirect_pc, inst_discard, div_start, div_done
  );

  modport slave (
    input  inst_busy, data_busy, id_load_use, ex_is_div, exc_in, exc_handler_pc,
    output stall, flush, pc_redirect, redirect_pc, inst_discard, div_start, div_done
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Central stall/flush sequencer for the five-stage pipeline.
//   - Builds the stall vector {data, exe, id, inst} and the exception flush.
//   - Sequences the fixed-latency multi-cycle divider in EX.
//   - Holds the PC redirect after an exception until an outstanding
//     instruction fetch has drained.
//
//   Ports:
//     clk   core clock
//     rst   asynchronous, active-low reset
//     pif   pipeline_ctrl_if.slave (hazard inputs, stall/flush/divider outputs)
//
//   Parameters:
//     DIV_CYCLES  EX cycles a DIV/DIVU occupies, including the start cycle (>=2)
//     CNT_W       divide counter width, must hold DIV_CYCLES-1
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  pif
);

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_RUN  = 2'd1,
    D_DONE = 2'd2
  } div_state_t;

  typedef enum logic {
    F_IDLE    = 1'b0,
    F_WAIT_IF = 1'b1
  } flush_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_t       div_state_q, div_state_d;
  flush_state_t     flush_state_q, flush_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d;

  // Ungated outputs; forced to zero below while reset is asserted.
  logic [3:0]  stall_raw;
  logic        flush_raw;
  logic        pc_redirect_raw;
  logic [31:0] redirect_pc_raw;
  logic        inst_discard_raw;
  logic        div_start_raw;
  logic        div_done_raw;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_state_q   <= D_IDLE;
      flush_state_q <= F_IDLE;
      cnt_q         <= '0;
      pc_q          <= '0;
    end else begin
      div_state_q   <= div_state_d;
      flush_state_q <= flush_state_d;
      cnt_q         <= cnt_d;
      pc_q          <= pc_d;
    end
  end

  // -------------------------------------------------------------------------
  // Exception flush / redirect sequencing
  // -------------------------------------------------------------------------
  always_comb begin
    flush_state_d    = flush_state_q;
    pc_d             = pc_q;
    flush_raw        = 1'b0;
    pc_redirect_raw  = 1'b0;
    redirect_pc_raw  = '0;
    inst_discard_raw = 1'b0;

    unique case (flush_state_q)
      F_IDLE: begin
        if (pif.exc_in) begin
          flush_raw = 1'b1;
          pc_d      = pif.exc_handler_pc;
          if (!pif.inst_busy) begin
            pc_redirect_raw = 1'b1;
            redirect_pc_raw = pif.exc_handler_pc;
          end else begin
            // The fetch already on the bus would land after the redirect;
            // wait for it and throw its data away.
            flush_state_d = F_WAIT_IF;
          end
        end
      end

      F_WAIT_IF: begin
        inst_discard_raw = 1'b1;
        if (pif.exc_in) begin
          flush_raw = 1'b1;
          pc_d      = pif.exc_handler_pc;
        end
        if (!pif.inst_busy) begin
          pc_redirect_raw = 1'b1;
          // A newer exception in the drain cycle wins over the latched one.
          redirect_pc_raw = pif.exc_in ? pif.exc_handler_pc : pc_q;
          flush_state_d   = F_IDLE;
        end
      end

      default: flush_state_d = F_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Divider sequencing and stall vector
  // -------------------------------------------------------------------------
  always_comb begin
    div_state_d   = div_state_q;
    cnt_d         = cnt_q;
    div_start_raw = 1'b0;
    div_done_raw  = 1'b0;
    stall_raw     = 4'b0000;

    unique case (div_state_q)
      D_IDLE: begin
        // After a flush the pipeline is empty while the fetch drains, so an
        // ex_is_div seen during F_WAIT_IF cannot be a live instruction.
        if (pif.ex_is_div && !flush_raw && (flush_state_q == F_IDLE)) begin
          div_start_raw = 1'b1;
          div_state_d   = D_RUN;
          cnt_d         = CNT_ONE;
        end
      end

      D_RUN: begin
        if (cnt_q == CNT_LAST) begin
          div_state_d = D_DONE;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      D_DONE: begin
        div_done_raw = 1'b1;
        // The result must stay valid until EX actually advances.
        if (!stall_raw[3]) begin
          div_state_d = D_IDLE;
        end
      end

      default: begin
        div_state_d = D_IDLE;
        cnt_d       = '0;
      end
    endcase

    if (flush_state_q == F_WAIT_IF) begin
      stall_raw = 4'b0001;
    end else begin
      stall_raw[3] = pif.data_busy;
      stall_raw[2] = ((div_state_q == D_RUN) || div_start_raw) && !flush_raw;
      stall_raw[1] = pif.id_load_use;
      stall_raw[0] = pif.inst_busy;
    end

    // D_DONE's exit test reads stall[3]; re-evaluate it now stall is final.
    if (div_state_q == D_DONE) begin
      div_state_d = stall_raw[3] ? D_DONE : D_IDLE;
    end

    // A flush kills whatever DIV occupies EX.
    if (flush_raw) begin
      div_state_d   = D_IDLE;
      cnt_d         = '0;
      div_done_raw  = 1'b0;
      div_start_raw = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs, silenced for the whole time reset is held
  // -------------------------------------------------------------------------
  always_comb begin
    pif.stall        = rst ? stall_raw        : 4'b0000;
    pif.flush        = rst ? flush_raw        : 1'b0;
    pif.pc_redirect  = rst ? pc_redirect_raw  : 1'b0;
    pif.redirect_pc  = rst ? redirect_pc_raw  : 32'h0;
    pif.inst_discard = rst ? inst_discard_raw : 1'b0;
    pif.div_start    = rst ? div_start_raw    : 1'b0;
    pif.div_done     = rst ? div_done_raw     : 1'b0;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Self-checking bench for pipeline_ctrl: a table of single-cycle vectors
//   from the idle state, then hand-written multi-cycle sequences (divide,
//   exception with fetch drain, exception mid-divide, async reset mid-wait).
//   Expected responses are queued when stimulus is driven and popped when
//   the outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int DIV_CYCLES = 33;

  typedef struct packed {
    logic        inst_busy;
    logic        data_busy;
    logic        id_load_use;
    logic        ex_is_div;
    logic        exc_in;
    logic [31:0] pc;
  } stim_t;

  typedef struct packed {
    logic [3:0]  stall;
    logic        flush;
    logic        pc_redirect;
    logic        inst_discard;
    logic        div_start;
    logic        div_done;
    logic [31:0] redirect_pc;
  } resp_t;

  typedef struct packed {
    stim_t s;
    resp_t r;
  } vec_t;

  logic clk;
  logic rst;
  pipeline_ctrl_if pif ();

  pipeline_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  resp_t exp_q[$];

  function automatic stim_t ms(logic ib, logic db, logic ilu, logic dv, logic ex,
                               logic [31:0] pc);
    stim_t s;
    s = '{inst_busy: ib, data_busy: db, id_load_use: ilu, ex_is_div: dv,
          exc_in: ex, pc: pc};
    return s;
  endfunction

  function automatic resp_t mr(logic [3:0] st, logic fl, logic pcr, logic disc,
                               logic ds, logic dd, logic [31:0] rpc);
    resp_t r;
    r = '{stall: st, flush: fl, pc_redirect: pcr, inst_discard: disc,
          div_start: ds, div_done: dd, redirect_pc: rpc};
    return r;
  endfunction

  function automatic resp_t sample();
    resp_t r;
    r = '{stall: pif.stall, flush: pif.flush, pc_redirect: pif.pc_redirect,
          inst_discard: pif.inst_discard, div_start: pif.div_start,
          div_done: pif.div_done, redirect_pc: pif.redirect_pc};
    return r;
  endfunction

  task automatic drive(input stim_t s);
    pif.inst_busy      = s.inst_busy;
    pif.data_busy      = s.data_busy;
    pif.id_load_use    = s.id_load_use;
    pif.ex_is_div      = s.ex_is_div;
    pif.exc_in         = s.exc_in;
    pif.exc_handler_pc = s.pc;
  endtask

  task automatic check(input string name, input resp_t act, input resp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got stall=%b fl=%b pcr=%b disc=%b ds=%b dd=%b rpc=%h, expected stall=%b fl=%b pcr=%b disc=%b ds=%b dd=%b rpc=%h",
               name, act.stall, act.flush, act.pc_redirect, act.inst_discard,
               act.div_start, act.div_done, act.redirect_pc,
               exp.stall, exp.flush, exp.pc_redirect, exp.inst_discard,
               exp.div_start, exp.div_done, exp.redirect_pc);
    end else begin
      $display("ok   %s: stall=%b fl=%b pcr=%b disc=%b ds=%b dd=%b rpc=%h",
               name, act.stall, act.flush, act.pc_redirect, act.inst_discard,
               act.div_start, act.div_done, act.redirect_pc);
    end
  endtask

  // One clock cycle: drive after the rising edge, compare on the falling edge.
  task automatic step(input string name, input stim_t s, input resp_t r);
    resp_t e;
    @(posedge clk);
    #1;
    drive(s);
    exp_q.push_back(r);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, sample(), e);
    end
  endtask

  localparam logic [31:0] EXC_PC = 32'hBFC00380;
  localparam resp_t       ZERO_R = '0;

  vec_t vecs[10];

  initial begin
    // Single-cycle vectors applied from the idle state; none leaves it.
    vecs[0] = '{s: ms(0,0,0,0,0,32'h0),      r: mr(4'b0000,0,0,0,0,0,32'h0)};
    vecs[1] = '{s: ms(1,0,0,0,0,32'h0),      r: mr(4'b0001,0,0,0,0,0,32'h0)};
    vecs[2] = '{s: ms(0,1,0,0,0,32'h0),      r: mr(4'b1000,0,0,0,0,0,32'h0)};
    vecs[3] = '{s: ms(0,0,1,0,0,32'h0),      r: mr(4'b0010,0,0,0,0,0,32'h0)};
    vecs[4] = '{s: ms(0,1,1,0,0,32'h0),      r: mr(4'b1010,0,0,0,0,0,32'h0)};
    vecs[5] = '{s: ms(1,1,1,0,0,32'h0),      r: mr(4'b1011,0,0,0,0,0,32'h0)};
    vecs[6] = '{s: ms(0,0,0,0,1,EXC_PC),     r: mr(4'b0000,1,1,0,0,0,EXC_PC)};
    vecs[7] = '{s: ms(0,0,0,0,0,EXC_PC),     r: mr(4'b0000,0,0,0,0,0,32'h0)};
    vecs[8] = '{s: ms(0,0,0,1,1,32'h80000180), r: mr(4'b0000,1,1,0,0,0,32'h80000180)};
    vecs[9] = '{s: ms(0,0,0,0,0,32'h0),      r: mr(4'b0000,0,0,0,0,0,32'h0)};

    // Reset held with busy inputs: every output must read zero.
    rst = 1'b0;
    drive(ms(1,1,1,1,1,EXC_PC));
    #12;
    check("reset_hold", sample(), ZERO_R);
    @(negedge clk);
    check("reset_hold2", sample(), ZERO_R);
    drive(ms(0,0,0,0,0,32'h0));
    rst = 1'b1;

    // Idle after reset release.
    for (int i = 0; i < 3; i++) step($sformatf("idle%0d", i), ms(0,0,0,0,0,32'h0), ZERO_R);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) step($sformatf("vec%0d", i), vecs[i].s, vecs[i].r);

    // Divide held in EX; MEM busy for 3 cycles once the result is ready.
    for (int c = 0; c <= 37; c++) begin
      logic db, dv, st2, ds, dd;
      db  = (c >= DIV_CYCLES) && (c <= DIV_CYCLES + 2);
      dv  = (c <= DIV_CYCLES + 3);
      st2 = (c < DIV_CYCLES);
      ds  = (c == 0);
      dd  = (c >= DIV_CYCLES) && (c <= DIV_CYCLES + 3);
      step($sformatf("div_c%0d", c), ms(0,db,0,dv,0,32'h0),
           mr({db, st2, 1'b0, 1'b0}, 0, 0, 0, ds, dd, 32'h0));
    end

    // Exception with a fetch outstanding for 5 more cycles.
    step("exc_busy_c0", ms(1,0,0,0,1,EXC_PC), mr(4'b0001,1,0,0,0,0,32'h0));
    for (int c = 1; c <= 5; c++)
      step($sformatf("exc_busy_c%0d", c), ms(1,0,0,0,0,32'h0), mr(4'b0001,0,0,1,0,0,32'h0));
    step("exc_busy_drop", ms(0,0,0,0,0,32'h0), mr(4'b0001,0,1,1,0,0,EXC_PC));
    step("exc_busy_after", ms(0,0,0,0,0,32'h0), ZERO_R);

    // Exception arriving at divide count 10.
    step("divx_c0", ms(0,0,0,1,0,32'h0), mr(4'b0100,0,0,0,1,0,32'h0));
    for (int c = 1; c < 10; c++)
      step($sformatf("divx_c%0d", c), ms(0,0,0,1,0,32'h0), mr(4'b0100,0,0,0,0,0,32'h0));
    step("divx_exc", ms(0,0,0,1,1,32'h80000180), mr(4'b0000,1,1,0,0,0,32'h80000180));
    for (int c = 0; c < DIV_CYCLES + 2; c++)
      step($sformatf("divx_post%0d", c), ms(0,0,0,0,0,32'h0), ZERO_R);

    // Async reset in the middle of F_WAIT_IF.
    step("rstw_exc", ms(1,0,0,0,1,32'h80000000), mr(4'b0001,1,0,0,0,0,32'h0));
    step("rstw_wait", ms(1,0,1,0,0,32'h0), mr(4'b0001,0,0,1,0,0,32'h0));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rstw_async", sample(), ZERO_R);
    @(negedge clk);
    check("rstw_held", sample(), ZERO_R);
    drive(ms(0,0,0,0,0,32'h0));
    rst = 1'b1;
    for (int c = 0; c < 4; c++)
      step($sformatf("rstw_post%0d", c), ms(0,0,0,0,0,32'h0), ZERO_R);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
